// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment scan decoder: digit count,
// active-low select codes for each position and the lock-state encoding.
package smg_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [5:0] SEL_BLANK = 6'b111111;
  localparam logic [5:0] SEL_POS0  = 6'b111110;
  localparam logic [5:0] SEL_POS1  = 6'b111101;
  localparam logic [5:0] SEL_POS2  = 6'b111011;
  localparam logic [5:0] SEL_POS3  = 6'b110111;
  localparam logic [5:0] SEL_POS4  = 6'b101111;
  localparam logic [5:0] SEL_POS5  = 6'b011111;

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

endpackage

// File: rtl/smg_run_filter.sv
// Select-bus glitch filter: measures how long sel has been stable, emits one
// accept pulse per dwell-qualified slot and classifies the select value.
module smg_run_filter
  import smg_pkg::*;
#(
  parameter int MIN_DWELL   = 16,
  parameter int SLOT_CYCLES = 5000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [5:0] sel,
  output logic       accept,
  output logic       isBlank,
  output logic       isIllegal,
  output logic [2:0] position
);

  localparam int CNT_W = $clog2(SLOT_CYCLES + 1);
  localparam logic [5:0] SEL_POS [NUM_DIGITS] =
    '{SEL_POS0, SEL_POS1, SEL_POS2, SEL_POS3, SEL_POS4, SEL_POS5};

  logic [5:0]            prevSelReg;
  logic [CNT_W-1:0]      runCntReg;
  logic [CNT_W-1:0]      runCntNext;
  logic [NUM_DIGITS-1:0] posHit;
  logic                  stable;
  logic                  blankWrap;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : gPosHit
      assign posHit[gi] = (sel == SEL_POS[gi]);
    end
  endgenerate

  assign stable    = (sel == prevSelReg);
  assign isBlank   = (sel == SEL_BLANK);
  assign isIllegal = !isBlank && (posHit == '0);

  // A long blank run spans several slots: restarting the run every
  // SLOT_CYCLES re-arms the dwell compare, giving one extra accept per slot.
  assign blankWrap = stable && isBlank && (runCntReg == CNT_W'(SLOT_CYCLES - 1));

  always_comb begin
    runCntNext = runCntReg + 1'b1;
    if (!stable || blankWrap) begin
      runCntNext = '0;
    end else if (runCntReg == CNT_W'(SLOT_CYCLES)) begin
      runCntNext = runCntReg;
    end
  end

  assign accept = (runCntNext == CNT_W'(MIN_DWELL - 1));

  always_comb begin
    position = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (posHit[i]) begin
        position = 3'(i);
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      prevSelReg <= '0;
      runCntReg  <= '0;
    end else begin
      prevSelReg <= sel;
      runCntReg  <= runCntNext;
    end
  end

endmodule

// File: rtl/smg_scan_decoder.sv
// Display readback monitor: follows the scan order of a six-digit multiplexed
// display and rebuilds the shown BCD frame plus its per-digit blank mask.
module smg_scan_decoder
  import smg_pkg::*;
#(
  parameter int MIN_DWELL   = 16,
  parameter int SLOT_CYCLES = 5000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [9:0]  iScan,
  output logic [23:0] oData,
  output logic [5:0]  oBlank,
  output logic        oValid,
  output logic        oSync,
  output logic        oErr
);

  logic       accept;
  logic       isBlank;
  logic       isIllegal;
  logic [2:0] position;
  logic [3:0] digit;

  logic [0:0]            stateReg;
  logic [2:0]            expectedPosReg;
  logic [3:0]            shadowDigitReg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadowBlankReg;
  logic                  frameDoneReg;
  logic [23:0]           frameWord;

  assign digit = iScan[9:6];

  smg_run_filter #(
    .MIN_DWELL  (MIN_DWELL),
    .SLOT_CYCLES(SLOT_CYCLES)
  ) uRunFilter (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .sel      (iScan[5:0]),
    .accept   (accept),
    .isBlank  (isBlank),
    .isIllegal(isIllegal),
    .position (position)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : gFrame
      assign frameWord[23-4*gi -: 4] = shadowDigitReg[gi];
    end
  endgenerate

  assign oSync = (stateReg == LOCK);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stateReg       <= HUNT;
      expectedPosReg <= 3'd0;
      shadowBlankReg <= '0;
      frameDoneReg   <= 1'b0;
      oErr           <= 1'b0;
      oValid         <= 1'b0;
      oData          <= '0;
      oBlank         <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadowDigitReg[i] <= '0;
      end
    end else begin
      frameDoneReg <= 1'b0;
      oErr         <= 1'b0;
      if (accept) begin
        if (stateReg == HUNT) begin
          if (!isBlank && !isIllegal && position == 3'd0) begin
            shadowDigitReg[0] <= digit;
            shadowBlankReg[0] <= 1'b0;
            expectedPosReg    <= 3'd1;
            stateReg          <= LOCK;
          end
        end else if (isIllegal || (!isBlank && position != expectedPosReg)) begin
          oErr           <= 1'b1;
          stateReg       <= HUNT;
          shadowBlankReg <= '0;
          expectedPosReg <= 3'd0;
        end else begin
          // A blank slot keeps the last visible digit so blink reads back stably.
          if (isBlank) begin
            shadowBlankReg[expectedPosReg] <= 1'b1;
          end else begin
            shadowDigitReg[expectedPosReg] <= digit;
            shadowBlankReg[expectedPosReg] <= 1'b0;
          end
          if (expectedPosReg == 3'd5) begin
            expectedPosReg <= 3'd0;
            frameDoneReg   <= 1'b1;
          end else begin
            expectedPosReg <= expectedPosReg + 3'd1;
          end
        end
      end
      if (frameDoneReg) begin
        oData  <= frameWord;
        oBlank <= shadowBlankReg;
      end
      oValid <= frameDoneReg;
    end
  end

endmodule

// File: tb/tb_smg_scan_decoder.sv
// Bench for smg_scan_decoder: table-driven frames plus hand-written scan
// sequences; expected frames are queued at drive time and popped on oValid.
module tb_smg_scan_decoder;
  import smg_pkg::*;

  localparam int DWELL = 16;
  localparam int SLOT  = 200;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [9:0]  iScan;
  logic [23:0] oData;
  logic [5:0]  oBlank;
  logic        oValid;
  logic        oSync;
  logic        oErr;

  smg_scan_decoder #(
    .MIN_DWELL  (DWELL),
    .SLOT_CYCLES(SLOT)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .iScan (iScan),
    .oData (oData),
    .oBlank(oBlank),
    .oValid(oValid),
    .oSync (oSync),
    .oErr  (oErr)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] data;
    logic [5:0]  blank;
    int          cycle;
  } exp_t;

  typedef struct {
    logic [23:0] digits;
    logic [5:0]  mask;
    logic [23:0] expData;
    logic [5:0]  expBlank;
  } vec_t;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;
  int   errPulses = 0;
  int   lastErrCycle = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge CLOCK) begin
    exp_t e;
    if (RESET === 1'b1 && oErr === 1'b1) begin
      errPulses++;
      lastErrCycle = cyc;
      $display("err pulse at cycle %0d", cyc);
    end
    if (RESET === 1'b1 && oValid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 data=%h blank=%b cycle=%0d",
                 oData, oBlank, cyc);
      end else begin
        e = sbQ.pop_front();
        $display("frame data=%h blank=%b sync=%b cycle=%0d", oData, oBlank, oSync, cyc);
        check("frame_data", 32'(oData), 32'(e.data));
        check("frame_blank", 32'(oBlank), 32'(e.blank));
        check("frame_sync", 32'(oSync), 32'd1);
        check("frame_latency", 32'(cyc), 32'(e.cycle));
      end
    end
  end

  // Holds one select value for n cycles; optionally queues the frame that the
  // slot completes, due DWELL cycles after the slot's first sampled edge.
  task automatic driveSel(input logic [5:0] sel, input logic [3:0] dig, input int n,
                          input bit push, input logic [23:0] expData, input logic [5:0] expBlank);
    @(negedge CLOCK);
    iScan = {dig, sel};
    if (push) sbQ.push_back('{expData, expBlank, cyc + 1 + DWELL});
    repeat (n - 1) @(negedge CLOCK);
  endtask

  function automatic logic [5:0] posSel(input int k);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << k);
  endfunction

  task automatic driveFrame(input logic [23:0] digits, input logic [5:0] mask, input bit push,
                            input logic [23:0] expData, input logic [5:0] expBlank);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      logic [5:0] sel;
      logic [3:0] d;
      sel = mask[k] ? SEL_BLANK : posSel(k);
      d   = mask[k] ? 4'hF : digits[23-4*k -: 4];
      driveSel(sel, d, SLOT, push && (k == NUM_DIGITS - 1), expData, expBlank);
    end
  endtask

  task automatic checkIdle(input string name);
    check({name, "_outputs"}, {oData, oBlank, oValid, oSync}, 32'd0);
    check({name, "_err"}, 32'(oErr), 32'd0);
  endtask

  vec_t rows [4];
  int   errBase;
  int   startCyc;

  initial begin
    rows[0] = '{24'h123456, 6'b000000, 24'h123456, 6'b000000};
    rows[1] = '{24'h123456, 6'b000100, 24'h123456, 6'b000100};
    rows[2] = '{24'h987654, 6'b000000, 24'h987654, 6'b000000};
    rows[3] = '{24'h024680, 6'b100001, 24'h924684, 6'b100001};

    RESET = 1'b0;
    iScan = {4'h0, SEL_BLANK};
    repeat (3) @(negedge CLOCK);
    checkIdle("reset");
    RESET = 1'b1;

    for (int r = 0; r < 4; r++) begin
      driveFrame(rows[r].digits, rows[r].mask, 1'b1, rows[r].expData, rows[r].expBlank);
    end
    check("table_drained", 32'(sbQ.size()), 32'd0);
    check("table_no_err", 32'(errPulses), 32'd0);

    errBase = errPulses;
    driveSel(SEL_POS0, 4'h1, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS1, 4'h2, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_BLANK, 4'hF, 2 * SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS4, 4'h5, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS5, 4'h6, SLOT, 1'b1, 24'h124656, 6'b001100);
    check("merged_no_err", 32'(errPulses - errBase), 32'd0);
    check("merged_drained", 32'(sbQ.size()), 32'd0);

    errBase = errPulses;
    driveSel(SEL_POS0, 4'h7, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS1, 4'h8, 5, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS2, 4'h8, 5, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS1, 4'h8, SLOT - 10, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS2, 4'h3, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS3, 4'h4, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS4, 4'h5, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS5, 4'h6, SLOT, 1'b1, 24'h783456, 6'b000000);
    check("glitch_no_err", 32'(errPulses - errBase), 32'd0);
    check("glitch_drained", 32'(sbQ.size()), 32'd0);

    errBase = errPulses;
    driveSel(SEL_POS0, 4'h1, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS1, 4'h2, SLOT, 1'b0, 24'h0, 6'h0);
    startCyc = cyc;
    driveSel(SEL_POS3, 4'h4, SLOT, 1'b0, 24'h0, 6'h0);
    check("order_err_count", 32'(errPulses - errBase), 32'd1);
    check("order_err_cycle", 32'(lastErrCycle), 32'(startCyc + DWELL + 1));
    check("order_sync", 32'(oSync), 32'd0);
    driveSel(6'b110011, 4'h0, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS4, 4'h5, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS5, 4'h6, SLOT, 1'b0, 24'h0, 6'h0);
    check("hunt_illegal_no_err", 32'(errPulses - errBase), 32'd1);
    driveFrame(24'h135790, 6'b000000, 1'b1, 24'h135790, 6'b000000);
    check("relock_drained", 32'(sbQ.size()), 32'd0);
    driveSel(SEL_POS0, 4'h2, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(6'b001111, 4'h0, SLOT, 1'b0, 24'h0, 6'h0);
    check("locked_illegal_err", 32'(errPulses - errBase), 32'd2);
    check("locked_illegal_sync", 32'(oSync), 32'd0);

    errBase = errPulses;
    driveFrame(24'h246802, 6'b000000, 1'b1, 24'h246802, 6'b000000);
    driveSel(SEL_POS0, 4'h9, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS1, 4'h9, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS2, 4'h9, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS3, 4'h9, SLOT / 2, 1'b0, 24'h0, 6'h0);
    check("pre_reset_data", 32'(oData), 32'h246802);
    #2 RESET = 1'b0;
    #1 checkIdle("midreset");
    @(negedge CLOCK);
    RESET = 1'b1;
    driveSel(SEL_POS4, 4'h9, SLOT, 1'b0, 24'h0, 6'h0);
    driveSel(SEL_POS5, 4'h9, SLOT, 1'b0, 24'h0, 6'h0);
    check("post_reset_no_valid", 32'(oValid | oSync), 32'd0);
    driveFrame(24'h314159, 6'b000000, 1'b1, 24'h314159, 6'b000000);
    check("post_reset_drained", 32'(sbQ.size()), 32'd0);
    check("post_reset_no_err", 32'(errPulses - errBase), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
